// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: FSM state encodings, default divisor and frame levels.
// The receive path imports this package so both ends agree on the divisor.
package uart_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam int   UART_CLKS_PER_BIT = 1248;
    localparam logic START_BIT         = 1'b0;
    localparam logic STOP_BIT          = 1'b1;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous show-ahead FIFO: dout always presents the head entry.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_push, do_pop;

    assign do_pop  = pop & ~empty_q;
    assign do_push = push & (~full_q | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == (AW+1)'(DEPTH));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage holds no control state, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;
    assign count = count_q;

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: bytes queue in a small FIFO and are shifted out LSB-first.
// Back-to-back frames run with no idle gap when the FIFO still holds data at STOP end.
import uart_tx_pkg::*;

module uart_tx #(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_push,
    output logic                 tx_full,
    output logic                 tx_empty,
    output logic                 tx_busy,
    output logic                 tx_overflow,
    output logic                 tx_bit
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);

    tx_state_e            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 bit_q, bit_d;
    logic                 busy_q, busy_d;
    logic                 ovf_q, ovf_d;

    logic                 pop;
    logic                 bit_done;
    logic                 fifo_avail;
    logic [DATA_BITS-1:0] fifo_dout;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_push),
        .pop   (pop),
        .din   (tx_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign fifo_avail = |fifo_count;
    assign bit_done   = (cnt_q == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            bit_q   <= STOP_BIT;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            bit_q   <= bit_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (fifo_avail) begin
                    pop     = 1'b1;
                    shift_d = fifo_dout;
                    state_d = START;
                end
            end
            START: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + IW'(1);
                    if (idx_q == IW'(DATA_BITS - 1)) state_d = STOP;
                end
            end
            STOP: begin
                if (bit_done) begin
                    cnt_d = '0;
                    // Chain straight into the next start bit when data is waiting.
                    if (fifo_avail) begin
                        pop     = 1'b1;
                        shift_d = fifo_dout;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        case (state_d)
            START:   bit_d = START_BIT;
            DATA:    bit_d = shift_d[0];
            default: bit_d = STOP_BIT;
        endcase
        busy_d = (state_d != IDLE);
        ovf_d  = ovf_q | (tx_push & fifo_full & ~pop);
    end

    assign tx_full     = fifo_full;
    assign tx_empty    = fifo_empty;
    assign tx_busy     = busy_q;
    assign tx_overflow = ovf_q;
    assign tx_bit      = bit_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with a short baud divisor: frame shapes, chaining,
// overflow, full-with-pop and mid-frame reset, all against hand-written frames.
module tb_uart_tx;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;   // line level per bit time, bit 0 = start bit
    } vec_t;

    logic       clk;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_push;
    logic       tx_full;
    logic       tx_empty;
    logic       tx_busy;
    logic       tx_overflow;
    logic       tx_bit;

    int total  = 0;
    int passed = 0;

    uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .DATA_BITS    (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tx_data     (tx_data),
        .tx_push     (tx_push),
        .tx_full     (tx_full),
        .tx_empty    (tx_empty),
        .tx_busy     (tx_busy),
        .tx_overflow (tx_overflow),
        .tx_bit      (tx_bit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic push_byte(input logic [7:0] d);
        tx_data = d;
        tx_push = 1'b1;
        @(negedge clk);
        tx_push = 1'b0;
    endtask

    task automatic do_reset();
        reset   = 1'b0;
        tx_push = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_start(input string name, input int budget);
        int n = 0;
        while (tx_bit !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, tx_bit, 1'b0);
    endtask

    // Called at the negedge holding cycle c0 of a frame; compares every cycle to the end.
    task automatic check_frame(input logic [9:0] fr, input string name, input int c0,
                               output int busy_n);
        int errs = 0;
        busy_n = 0;
        for (int c = c0; c < 10*CPB; c++) begin
            if (tx_bit !== fr[c / CPB]) errs++;
            if (tx_busy === 1'b1) busy_n++;
            tx_data = 8'($urandom);
            @(negedge clk);
        end
        check(name, errs, 0);
    endtask

    vec_t vecs[6];

    initial begin
        int b1, b2, lows;
        logic [7:0]  d;
        logic [9:0]  f3[5];
        logic [9:0]  f4[4];

        vecs[0] = '{8'h00, 10'b1000000000};
        vecs[1] = '{8'hFF, 10'b1111111110};
        vecs[2] = '{8'h55, 10'b1010101010};
        vecs[3] = '{8'hA5, 10'b1101001010};
        vecs[4] = '{8'h80, 10'b1100000000};
        vecs[5] = '{8'h01, 10'b1000000010};
        f3[0] = 10'b1000000010; f3[1] = 10'b1000000100; f3[2] = 10'b1000000110;
        f3[3] = 10'b1000001000; f3[4] = 10'b1000001010;
        f4[0] = 10'b1001000000; f4[1] = 10'b1001100000;
        f4[2] = 10'b1010000000; f4[3] = 10'b1010100000;

        reset   = 1'b0;
        tx_push = 1'b0;
        tx_data = 8'h00;
        repeat (3) @(negedge clk);
        check("reset tx_bit", tx_bit, 1'b1);
        check("reset tx_busy", tx_busy, 1'b0);
        check("reset tx_empty", tx_empty, 1'b1);
        check("reset tx_full", tx_full, 1'b0);
        check("reset tx_overflow", tx_overflow, 1'b0);
        reset = 1'b1;
        @(negedge clk);

        // Single byte: latency, frame shape, busy length
        push_byte(8'h47);
        check("t1 empty after push", tx_empty, 1'b0);
        check("t1 line high before pop", tx_bit, 1'b1);
        @(negedge clk);
        check("t1 start bit 2 edges after push", tx_bit, 1'b0);
        check("t1 busy at start", tx_busy, 1'b1);
        check_frame(10'b1010001110, "t1 frame 0x47", 0, b1);
        check("t1 busy cycles", b1, 10*CPB);
        check("t1 idle busy", tx_busy, 1'b0);
        check("t1 idle line", tx_bit, 1'b1);
        check("t1 idle empty", tx_empty, 1'b1);

        // Table of single frames
        for (int i = 0; i < 6; i++) begin
            push_byte(vecs[i].data);
            wait_start("tbl start", 8);
            check_frame(vecs[i].frame, "tbl frame", 0, b1);
            check("tbl idle after frame", {tx_busy, tx_empty, tx_bit}, 3'b011);
        end

        // Back-to-back frames
        tx_data = 8'h47; tx_push = 1'b1;
        @(negedge clk);
        tx_data = 8'hFE;
        @(negedge clk);
        tx_push = 1'b0;
        wait_start("t2 start", 8);
        check_frame(10'b1010001110, "t2 frame 0x47", 0, b1);
        check("t2 contiguous start", tx_bit, 1'b0);
        check_frame(10'b1111111100, "t2 frame 0xFE", 0, b2);
        check("t2 busy cycles", b1 + b2, 20*CPB);
        check("t2 idle", {tx_busy, tx_empty, tx_bit}, 3'b011);

        // Overflow: sixth byte dropped
        for (int i = 1; i <= 6; i++) begin
            d = 8'(i);
            tx_data = d; tx_push = 1'b1;
            @(negedge clk);
            if (i == 5) begin
                check("t3 full after 0x05", tx_full, 1'b1);
                check("t3 no overflow yet", tx_overflow, 1'b0);
            end
        end
        tx_push = 1'b0;
        check("t3 overflow set", tx_overflow, 1'b1);
        check("t3 still full", tx_full, 1'b1);
        check_frame(f3[0], "t3 frame 0x01", 4, b1);
        for (int i = 1; i < 5; i++) begin
            check("t3 contiguous start", tx_bit, 1'b0);
            check_frame(f3[i], "t3 frame", 0, b1);
        end
        lows = 0;
        for (int c = 0; c < 3*CPB; c++) begin
            if (tx_bit !== 1'b1) lows++;
            @(negedge clk);
        end
        check("t3 no sixth frame", lows, 0);
        check("t3 overflow sticky", tx_overflow, 1'b1);
        do_reset();
        check("t3 overflow cleared by reset", tx_overflow, 1'b0);

        // Full FIFO with push on the STOP->START edge
        push_byte(8'h10);
        @(negedge clk);
        check("t4 frame1 start", tx_bit, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tx_data = 8'(8'h20 + 8'(i) * 8'h10); tx_push = 1'b1;
            @(negedge clk);
        end
        tx_push = 1'b0;
        repeat (10*CPB - 1 - 4) @(negedge clk);
        check("t4 full before chain edge", tx_full, 1'b1);
        check("t4 stop bit before chain edge", tx_bit, 1'b1);
        tx_data = 8'hA5; tx_push = 1'b1;
        @(negedge clk);
        tx_push = 1'b0;
        check("t4 chained start", tx_bit, 1'b0);
        check("t4 full after push+pop", tx_full, 1'b1);
        check("t4 no overflow", tx_overflow, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check_frame(f4[i], "t4 frame", 0, b1);
            check("t4 contiguous start", tx_bit, 1'b0);
        end
        check_frame(10'b1101001010, "t4 frame 0xA5 last", 0, b1);
        check("t4 idle", {tx_busy, tx_empty, tx_overflow}, 3'b010);

        // Reset in the middle of the third data bit
        tx_data = 8'h00; tx_push = 1'b1;
        @(negedge clk);
        tx_data = 8'h33;
        @(negedge clk);
        tx_push = 1'b0;
        check("t5 start", tx_bit, 1'b0);
        repeat (3*CPB + CPB/2) @(negedge clk);
        check("t5 in data bit 2", {tx_busy, tx_bit}, 2'b10);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("t5 line high after reset", tx_bit, 1'b1);
        check("t5 not busy after reset", tx_busy, 1'b0);
        check("t5 fifo flushed", tx_empty, 1'b1);
        lows = 0;
        for (int c = 0; c < 20000; c++) begin
            @(negedge clk);
            if (tx_bit !== 1'b1 || tx_busy !== 1'b0) lows++;
        end
        check("t5 quiet after reset", lows, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Stand-alone 8N1 UART transmitter: the serializing counterpart to the existing UART receive path.
- Bytes are pushed in parallel into a small TX FIFO. Each byte is shifted out LSB-first on tx_bit at a fixed integer baud divisor.
- Sits beside the UART receiver in the top level, and drives the board TX pin or a loopback into the receiver's rx_bit.
- Same 12 MHz reference clock domain as the receiver.

Parameters:
- CLKS_PER_BIT, 1248, clk cycles per serial bit (12 MHz / ~9600 baud); must be >= 2
- FIFO_DEPTH, 4, TX FIFO entries; power of two, >= 2
- DATA_BITS, 8, bits per frame, fixed at 8 in this revision

Ports:
- clk  in  1  reference clock, 12 MHz
- reset  in  1  synchronous, active-low reset (0 = reset), sampled on rising clk
- tx_data  in  8  byte to enqueue
- tx_push  in  1  enqueue strobe, one byte per cycle while high
- tx_full  out  1  FIFO full
- tx_empty  out  1  FIFO empty
- tx_busy  out  1  frame in progress (state != IDLE)
- tx_overflow  out  1  sticky: a push was dropped while full
- tx_bit  out  1  serial line, idle high

Behaviour:
- All outputs are registered.
- Reset values: tx_bit=1, tx_busy=0, tx_empty=1, tx_full=0, tx_overflow=0; FIFO pointers and count=0; state=IDLE.
- FIFO push: on a rising edge with tx_push=1, tx_data is written if not full. It is also written when full and a pop happens on the same edge; the count is then unchanged.
- Push while full without a same-edge pop: byte dropped, tx_overflow set. tx_overflow clears only on reset.
- Pointers wrap modulo FIFO_DEPTH.
- Count width is clog2(FIFO_DEPTH)+1, so full (count==DEPTH) and empty (count==0) are unambiguous.
- States: IDLE, START, DATA, STOP.
- IDLE: tx_bit=1. If FIFO not empty: pop the head into an 8-bit shift register, clear the baud counter, go to START. Pop and state change happen on the same edge.
- START: tx_bit=0 for CLKS_PER_BIT cycles, then go to DATA with bit index=0.
- DATA: tx_bit=shift[0] for CLKS_PER_BIT cycles, then shift right and increment the index. After index 7 completes, go to STOP.
- STOP: tx_bit=1 for CLKS_PER_BIT cycles. At the end, if the FIFO is not empty, pop and go directly to START (no idle gap); else go to IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1, and the bit ends on the terminal count.
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- Latency: a push on edge N into an empty FIFO with state IDLE gives tx_empty=0 after edge N. The pop happens at edge N+1, and tx_bit=0 is driven from edge N+1. The start bit therefore appears 2 edges after the push is sampled.
- tx_busy=1 from the first START edge until the edge returning to IDLE.
- tx_data changing during a frame has no effect on the frame in flight.
- Reset asserted mid-frame: on the next edge tx_bit=1, state=IDLE, FIFO flushed. The partial frame is abandoned; the line stays high for at least 1 cycle before any new start bit.

Decomposition:
- Shared include uart_defs.vh holds:
  - state encodings (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3)
  - UART_CLKS_PER_BIT default 1248
  - frame constants (START_BIT=1'b0, STOP_BIT=1'b1)
- The receiver must use the same include so both ends agree on the divisor.
- One sub-module: uart_tx_fifo (synchronous FIFO, params DEPTH/WIDTH, ports push/pop/din/dout/full/empty/count).
- The RX side reuses uart_tx_fifo later.

Test Plan:
1. Single byte: after reset release, push 0x47 once → tx_bit falls 2 edges after the push. The line then reads 0,1,1,1,0,0,0,1,0,1, each level held exactly 1248 cycles. tx_busy is high for 12480 cycles, then tx_bit=1 and tx_empty=1.
2. Back-to-back: push 0x47 then 0xFE on consecutive cycles → two contiguous frames, 24960 cycles total. The second start bit begins on the edge right after the first stop bit ends; no extra idle cycles.
3. Overflow: push 6 bytes 0x01..0x06 on consecutive cycles → 0x01 is popped on the edge after its push. 0x02..0x05 fill the FIFO and tx_full=1; 0x06 is dropped and tx_overflow=1. Exactly 5 frames follow (0x01..0x05), and tx_overflow stays 1.
4. Full with simultaneous pop: fill the FIFO during frame 1, then push 0xA5 on the STOP→START edge → byte accepted, no overflow, and 0xA5 is transmitted last.
5. Reset mid-frame: push 0x00, assert reset (0) for 1 cycle at the 3rd data bit → tx_bit=1 the next edge, tx_busy=0, tx_empty=1. No further transitions for 20000 cycles.
6. Loopback: tx_bit wired to the existing receiver's rx_bit. Push 0x47 then 0x7F, then read the RX data address twice over the bus → read data 0x47 then 0x7F.
